// File: rtl/reg_file_wb_if.sv
// reg_file_wb_if: write-back and operand-read bus of the register file
interface reg_file_wb_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
);
  logic              reg_write;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic [ADDR_W-1:0] read_reg1;
  logic [ADDR_W-1:0] read_reg2;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;
  logic              wr_ack;
  modport master (
    output reg_write, write_reg, write_data, read_reg1, read_reg2,
    input  read_data1, read_data2, wr_ack
  );
  modport slave (
    input  reg_write, write_reg, write_data, read_reg1, read_reg2,
    output read_data1, read_data2, wr_ack
  );
endinterface

// File: rtl/reg_file_wb.sv
// reg_file_wb: 2-read/1-write architectural register file with zero register and optional write bypass
module reg_file_wb #(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31,
  parameter int BYPASS   = 1
) (
  input logic          clk,
  input logic          reset_n,
  reg_file_wb_if.slave bus
);
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);
  localparam logic [ADDR_W:0]   NREGS    = (ADDR_W+1)'(NUM_REGS);
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              wr_ack_q, wr_ack_d;
  logic              wr_en;
  logic [ADDR_W-1:0] rd_idx [2];
  logic [DATA_W-1:0] rd_val [2];
  assign wr_en = bus.reg_write && (bus.write_reg != ZERO_IDX) && ({1'b0, bus.write_reg} < NREGS);
  always_comb begin
    regs_d   = regs_q;
    wr_ack_d = wr_en;
    if (wr_en) regs_d[bus.write_reg] = bus.write_data;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      wr_ack_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      wr_ack_q <= wr_ack_d;
    end
  end
  assign rd_idx[0] = bus.read_reg1;
  assign rd_idx[1] = bus.read_reg2;
  // zero/out-of-range reads beat the bypass, which beats storage
  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic valid, hit;
    assign valid     = (rd_idx[p] != ZERO_IDX) && ({1'b0, rd_idx[p]} < NREGS);
    assign hit       = (BYPASS != 0) && bus.reg_write && (bus.write_reg == rd_idx[p]);
    assign rd_val[p] = !valid ? '0 : hit ? bus.write_data : regs_q[rd_idx[p]];
  end
  assign bus.read_data1 = rd_val[0];
  assign bus.read_data2 = rd_val[1];
  assign bus.wr_ack     = wr_ack_q;
endmodule

// File: tb/tb_reg_file_wb.sv
// tb_reg_file_wb: random + directed checks of bypass and non-bypass register files against a behavioural model
module tb_reg_file_wb;
  logic clk = 0;
  logic reset_n = 1;
  logic we = 0;
  logic [4:0] wr = 0, r1 = 0, r2 = 0;
  logic [63:0] wd = 0;
  logic [63:0] model [32];
  logic ack_exp = 0;
  bit started = 0;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  reg_file_wb_if #(.DATA_W(64), .ADDR_W(5)) ifb ();
  reg_file_wb_if #(.DATA_W(64), .ADDR_W(5)) ifn ();
  assign ifb.reg_write = we;
  assign ifb.write_reg = wr;
  assign ifb.write_data = wd;
  assign ifb.read_reg1 = r1;
  assign ifb.read_reg2 = r2;
  assign ifn.reg_write = we;
  assign ifn.write_reg = wr;
  assign ifn.write_data = wd;
  assign ifn.read_reg1 = r1;
  assign ifn.read_reg2 = r2;
  reg_file_wb #(.BYPASS(1)) dut_b (.clk(clk), .reset_n(reset_n), .bus(ifb.slave));
  reg_file_wb #(.BYPASS(0)) dut_n (.clk(clk), .reset_n(reset_n), .bus(ifn.slave));
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [63:0] exp_rd(input logic [4:0] idx, input bit byp);
    if (idx == 5'd31) return 64'd0;
    if (byp && we && wr == idx) return wd;
    return model[idx];
  endfunction
  // reference state: a write lands when enabled and not aimed at R31
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) model[i] <= 64'd0;
      ack_exp <= 1'b0;
    end else begin
      ack_exp <= we && wr != 5'd31;
      if (we && wr != 5'd31) model[wr] <= wd;
    end
  end
  always @(negedge clk) begin
    #2;
    if (started) begin
      chk("byp_rd1", ifb.read_data1, exp_rd(r1, 1));
      chk("byp_rd2", ifb.read_data2, exp_rd(r2, 1));
      chk("byp_ack", {63'd0, ifb.wr_ack}, {63'd0, ack_exp});
      chk("nob_rd1", ifn.read_data1, exp_rd(r1, 0));
      chk("nob_rd2", ifn.read_data2, exp_rd(r2, 0));
      chk("nob_ack", {63'd0, ifn.wr_ack}, {63'd0, ack_exp});
    end
  end
  task automatic cyc(input logic w, input logic [4:0] a, input logic [63:0] d,
                     input logic [4:0] x, input logic [4:0] y);
    @(negedge clk);
    we = w; wr = a; wd = d; r1 = x; r2 = y;
    #3;
  endtask
  initial begin
    #1 reset_n = 0;
    started = 1;
    for (int i = 0; i < 32; i++) begin
      cyc(0, 0, 0, 5'(i), 5'(31 - i));
      chk("rst_rd1", ifb.read_data1, 64'd0);
      chk("rst_rd2", ifn.read_data2, 64'd0);
    end
    chk("rst_ack", {63'd0, ifb.wr_ack}, 64'd0);
    @(negedge clk) reset_n = 1;
    cyc(1, 5, 64'h0123_4567_89AB_CDEF, 5, 4);
    cyc(0, 0, 0, 5, 4);
    chk("r5_rd1", ifn.read_data1, 64'h0123_4567_89AB_CDEF);
    chk("r4_rd2", ifn.read_data2, 64'd0);
    chk("r5_ack", {63'd0, ifn.wr_ack}, 64'd1);
    cyc(0, 0, 0, 5, 4);
    chk("r5_ack_once", {63'd0, ifn.wr_ack}, 64'd0);
    cyc(1, 31, 64'hFFFF_FFFF_FFFF_FFFF, 31, 31);
    chk("xzr_byp", ifb.read_data1, 64'd0);
    cyc(0, 0, 0, 31, 31);
    chk("xzr_rd", ifn.read_data2, 64'd0);
    chk("xzr_ack", {63'd0, ifb.wr_ack}, 64'd0);
    cyc(1, 7, 64'hDEAD_BEEF, 7, 7);
    chk("byp_r7_1", ifb.read_data1, 64'hDEAD_BEEF);
    chk("byp_r7_2", ifb.read_data2, 64'hDEAD_BEEF);
    chk("nob_r7_1", ifn.read_data1, 64'd0);
    chk("nob_r7_2", ifn.read_data2, 64'd0);
    cyc(0, 0, 0, 7, 7);
    chk("nob_r7_after", ifn.read_data1, 64'hDEAD_BEEF);
    cyc(1, 10, 64'hAA, 10, 10);
    cyc(1, 10, 64'h55, 10, 10);
    chk("b2b_ack1", {63'd0, ifb.wr_ack}, 64'd1);
    cyc(0, 0, 0, 10, 10);
    chk("b2b_ack2", {63'd0, ifb.wr_ack}, 64'd1);
    chk("b2b_r10", ifn.read_data1, 64'h55);
    for (int i = 0; i < 31; i++) cyc(1, 5'(i), 64'(i) * 64'h1111, 5'(i), 5'(30 - i));
    cyc(0, 0, 0, 3, 30);
    chk("fill_r3", ifn.read_data1, 64'h3333);
    chk("fill_r30", ifn.read_data2, 64'h1_FFFE);
    cyc(1, 3, 64'hBAD0_BAD0, 3, 4);
    reset_n = 0;
    #1;
    chk("rst_ack_drop", {63'd0, ifb.wr_ack}, 64'd0);
    chk("rst_r4", ifn.read_data2, 64'd0);
    cyc(1, 3, 64'hBAD0_BAD0, 3, 4);
    @(negedge clk) reset_n = 1;
    we = 0;
    for (int i = 0; i < 32; i++) begin
      cyc(0, 0, 0, 5'(i), 5'(i));
      chk("post_rst", ifn.read_data1, 64'd0);
    end
    for (int n = 0; n < 400; n++) begin
      logic [4:0] a;
      a = 5'($urandom_range(0, 31));
      cyc(1'($urandom_range(0, 1)), a, {$urandom, $urandom},
          ($urandom_range(0, 2) == 0) ? a : 5'($urandom_range(0, 31)),
          ($urandom_range(0, 2) == 0) ? a : 5'($urandom_range(0, 31)));
    end
    cyc(0, 0, 0, 0, 0);
    @(negedge clk);
    #4;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
